adsr_vca: RTL and testbench

- Amplitude-envelope stage placed directly downstream of the FM synthesizer.
- Consumes the synthesizer's 24-bit signed sample stream and runs an ADSR envelope generator from a gate input.
- Multiplies each sample by the current envelope level and emits the shaped stream to the audio output path.
- The envelope advances once per accepted sample, so all rates are expressed per audio sample.

---
 rtl/env_pkg.sv | 16 +
 rtl/axis_if.sv | 23 ++
 rtl/env_vca_mult.sv | 41 ++++
 rtl/adsr_vca.sv | 129 ++++++++++++
 tb/tb_adsr_vca.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/env_pkg.sv
// Shared envelope types and constants.
// Used by the ADSR VCA datapath and its multiplier.
package env_pkg;

  localparam int LEVEL_W = 24;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 24'hFFFFFF;

  typedef enum logic [2:0] {
    ENV_IDLE    = 3'd0,
    ENV_ATTACK  = 3'd1,
    ENV_DECAY   = 3'd2,
    ENV_SUSTAIN = 3'd3,
    ENV_RELEASE = 3'd4
  } env_state_t;

endpackage

// File: rtl/axis_if.sv
// Minimal valid/ready stream bundle.
// Master drives valid/data, slave drives ready.
interface Axis_If #(
  parameter int W = 24
);

  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport Master (
    output valid,
    output data,
    input  ready
  );

  modport Slave (
    input  valid,
    input  data,
    output ready
  );

endinterface

// File: rtl/env_vca_mult.sv
// Two-stage 24x25 signed multiply, enable-gated.
// Ports: clk, reset, en, sample (1.23), level (0.24), result (1.23).
module env_vca_mult
  import env_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic signed [LEVEL_W-1:0] sample,
  input  logic        [LEVEL_W-1:0] level,
  output logic signed [LEVEL_W-1:0] result
);

  logic signed [LEVEL_W-1:0] a_q;
  logic signed [LEVEL_W:0]   b_q;
  logic signed [47:0]        a_x;
  logic signed [47:0]        b_x;
  logic signed [47:0]        prod;
  logic                      unused_lo;

  // b is non-negative and below 2^24, so the
  // product always fits in 48 bits.
  assign a_x  = 48'(a_q);
  assign b_x  = 48'(b_q);
  assign prod = a_x * b_x;

  assign unused_lo = ^prod[23:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      result <= '0;
    end else if (en) begin
      a_q    <= sample;
      b_q    <= {1'b0, level};
      result <= prod[47:24];
    end
  end

endmodule

// File: rtl/adsr_vca.sv
// ADSR envelope generator driving a VCA on a sample stream.
// Ports: clk, reset, gate, rates, signal_in/out, env_level/state, active.
module adsr_vca
  import env_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               gate,
  input  logic [LEVEL_W-1:0] attack_rate,
  input  logic [LEVEL_W-1:0] decay_rate,
  input  logic [LEVEL_W-1:0] sustain_level,
  input  logic [LEVEL_W-1:0] release_rate,
  Axis_If.Slave              signal_in,
  Axis_If.Master             signal_out,
  output logic [LEVEL_W-1:0] env_level,
  output logic [2:0]         env_state,
  output logic               active
);

  env_state_t         st_q;
  env_state_t         st_d;
  logic [LEVEL_W-1:0] lvl_d;
  logic [LEVEL_W:0]   atk_sum;
  logic [LEVEL_W-1:0] dcy_gap;
  logic [LEVEL_W-1:0] prod_hi;
  logic               en;
  logic               acc;
  logic               v1_q;
  logic               v2_q;

  assign en  = !v2_q || signal_out.ready;
  assign acc = signal_in.valid && en;

  assign signal_in.ready  = en;
  assign signal_out.valid = v2_q;
  assign signal_out.data  = prod_hi;
  assign env_state        = st_q;

  assign atk_sum = {1'b0, env_level}
                 + {1'b0, attack_rate};
  assign dcy_gap = env_level - sustain_level;

  always_comb begin
    st_d  = st_q;
    lvl_d = env_level;
    if (acc) begin
      unique case (st_q)
        ENV_IDLE: begin
          if (gate) st_d = ENV_ATTACK;
        end
        ENV_ATTACK: begin
          if (!gate) begin
            st_d = ENV_RELEASE;
          end else if (attack_rate == '0 ||
                       atk_sum >= {1'b0, LEVEL_MAX}) begin
            lvl_d = LEVEL_MAX;
            st_d  = ENV_DECAY;
          end else begin
            lvl_d = atk_sum[LEVEL_W-1:0];
          end
        end
        ENV_DECAY: begin
          // dcy_gap is only meaningful when the level
          // is above sustain, hence the explicit guard.
          if (!gate) begin
            st_d = ENV_RELEASE;
          end else if (decay_rate == '0 ||
                       env_level <= sustain_level ||
                       dcy_gap <= decay_rate) begin
            lvl_d = sustain_level;
            st_d  = ENV_SUSTAIN;
          end else begin
            lvl_d = env_level - decay_rate;
          end
        end
        ENV_SUSTAIN: begin
          if (!gate) st_d = ENV_RELEASE;
          else lvl_d = sustain_level;
        end
        ENV_RELEASE: begin
          // Retrigger keeps the current level.
          if (gate) begin
            st_d = ENV_ATTACK;
          end else if (release_rate == '0 ||
                       env_level <= release_rate) begin
            lvl_d = '0;
            st_d  = ENV_IDLE;
          end else begin
            lvl_d = env_level - release_rate;
          end
        end
        default: begin
          lvl_d = '0;
          st_d  = ENV_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q      <= ENV_IDLE;
      env_level <= '0;
      active    <= 1'b0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
    end else begin
      st_q      <= st_d;
      env_level <= lvl_d;
      active    <= (st_d != ENV_IDLE);
      if (en) begin
        v1_q <= signal_in.valid;
        v2_q <= v1_q;
      end
    end
  end

  // The multiplier sees the level held before this
  // accept's update.
  env_vca_mult u_mult (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .sample (signal_in.data),
    .level  (env_level),
    .result (prod_hi)
  );

endmodule

// File: tb/tb_adsr_vca.sv
// Scoreboard bench for adsr_vca.
// Envelope model plus queued expected samples.
module tb_adsr_vca;
  import env_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        gate = 1'b0;
  logic [23:0] ar = '0;
  logic [23:0] dr = '0;
  logic [23:0] sl = '0;
  logic [23:0] rr = '0;
  logic [23:0] env_level;
  logic [2:0]  env_state;
  logic        active;

  Axis_If #(.W(24)) sin ();
  Axis_If #(.W(24)) sout ();

  adsr_vca dut (
    .clk           (clk),
    .reset         (reset),
    .gate          (gate),
    .attack_rate   (ar),
    .decay_rate    (dr),
    .sustain_level (sl),
    .release_rate  (rr),
    .signal_in     (sin),
    .signal_out    (sout),
    .env_level     (env_level),
    .env_state     (env_state),
    .active        (active)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [23:0] q[$];
  longint      m_lvl = 0;
  int          m_st = 0;
  logic        n_gate = 1'b0;
  logic [23:0] n_ar = '0;
  logic [23:0] n_dr = '0;
  logic [23:0] n_sl = '0;
  logic [23:0] n_rr = '0;
  logic        held = 1'b0;
  logic [23:0] held_d = '0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] vca(
    input logic [23:0] s, input longint l);
    longint sx;
    longint p;
    sx = longint'($signed(s));
    p  = sx * l;
    return p[47:24];
  endfunction

  task automatic m_step();
    longint l;
    l = m_lvl;
    if (!gate && m_st >= 1 && m_st <= 3) begin
      m_st = 4;
    end else if (gate && (m_st == 0 || m_st == 4)) begin
      m_st = 1;
    end else begin
      case (m_st)
        1: begin
          l = l + longint'(ar);
          if (ar == 0 || l >= 64'hFFFFFF) begin
            l = 64'hFFFFFF;
            m_st = 2;
          end
        end
        2: begin
          l = l - longint'(dr);
          if (dr == 0 || l <= longint'(sl)) begin
            l = longint'(sl);
            m_st = 3;
          end
        end
        3: l = longint'(sl);
        4: begin
          l = l - longint'(rr);
          if (rr == 0 || l <= 0) begin
            l = 0;
            m_st = 0;
          end
        end
        default: ;
      endcase
    end
    m_lvl = l;
  endtask

  task automatic cyc(input logic v,
                     input logic [23:0] d,
                     input logic rdy);
    @(negedge clk);
    chk("env_level", env_level, m_lvl[23:0]);
    chk("env_state", env_state, m_st);
    chk("active", active, m_st != 0);
    if (held) begin
      chk("hold_valid", sout.valid, 1);
      chk("hold_data", sout.data, held_d);
    end
    gate = n_gate;
    ar = n_ar;
    dr = n_dr;
    sl = n_sl;
    rr = n_rr;
    sin.valid = v;
    sin.data = d;
    sout.ready = rdy;
    #1;
    if (sout.valid && sout.ready) begin
      chk("out_expected", q.size() > 0, 1);
      if (q.size() > 0)
        chk("out_data", sout.data, q.pop_front());
    end
    held = sout.valid && !sout.ready;
    held_d = sout.data;
    if (sin.valid && sin.ready) begin
      q.push_back(vca(d, m_lvl));
      m_step();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    m_lvl = 0;
    m_st = 0;
    held = 1'b0;
    chk("rst_valid", sout.valid, 0);
    chk("rst_data", sout.data, 0);
    chk("rst_ready", sin.ready, 1);
    chk("rst_level", env_level, 0);
    chk("rst_state", env_state, 0);
    chk("rst_active", active, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && q.size() > 0; i++)
      cyc(1'b0, 24'h0, 1'b1);
    chk("drain", q.size(), 0);
  endtask

  task automatic env_is(input string tag,
                        input logic [23:0] lvl,
                        input logic [2:0] st);
    cyc(1'b0, 24'h0, 1'b1);
    chk({tag, "_lvl"}, env_level, lvl);
    chk({tag, "_st"}, env_state, st);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    sin.valid = 1'b0;
    sin.data = '0;
    sout.ready = 1'b1;

    // reset and idle pass-through
    do_reset();
    cyc(1'b1, 24'h400000, 1'b1);
    cyc(1'b0, 24'h0, 1'b1);
    chk("lat_c1", sout.valid, 0);
    cyc(1'b0, 24'h0, 1'b1);
    chk("lat_c2", sout.valid, 1);
    repeat (5) cyc(1'b1, 24'h400000, 1'b1);
    drain();
    chk("idle_active", active, 0);

    // attack saturation, decay to sustain
    n_gate = 1'b1;
    n_ar = 24'h100000;
    n_dr = 24'h080000;
    n_sl = 24'h800000;
    n_rr = 24'h100000;
    repeat (16) cyc(1'b1, 24'h7FFFFF, 1'b1);
    env_is("atk15", 24'hF00000, 3'd1);
    cyc(1'b1, 24'h7FFFFF, 1'b1);
    env_is("atk16", 24'hFFFFFF, 3'd2);
    cyc(1'b1, 24'h800000, 1'b1);
    repeat (14) cyc(1'b1, 24'h7FFFFF, 1'b1);
    env_is("dcy15", 24'h87FFFF, 3'd2);
    cyc(1'b1, 24'h7FFFFF, 1'b1);
    env_is("dcy16", 24'h800000, 3'd3);

    // release and retrigger
    n_gate = 1'b0;
    repeat (4) cyc(1'b1, 24'h7FFFFF, 1'b1);
    env_is("rel3", 24'h500000, 3'd4);
    n_gate = 1'b1;
    cyc(1'b1, 24'h7FFFFF, 1'b1);
    env_is("retrig", 24'h500000, 3'd1);
    cyc(1'b1, 24'h7FFFFF, 1'b1);
    env_is("retrig1", 24'h600000, 3'd1);
    repeat (40) cyc(1'b1, 24'h7FFFFF, 1'b1);
    env_is("sus2", 24'h800000, 3'd3);
    n_gate = 1'b0;
    repeat (8) cyc(1'b1, 24'h7FFFFF, 1'b1);
    env_is("rel7", 24'h100000, 3'd4);
    cyc(1'b1, 24'h7FFFFF, 1'b1);
    env_is("rel8", 24'h000000, 3'd0);
    drain();

    // zero rates
    do_reset();
    n_ar = '0;
    n_dr = '0;
    n_rr = '0;
    n_sl = 24'h400000;
    n_gate = 1'b1;
    cyc(1'b1, 24'h7FFFFF, 1'b1);
    cyc(1'b1, 24'h800000, 1'b1);
    env_is("z_atk", 24'hFFFFFF, 3'd2);
    cyc(1'b1, 24'h7FFFFF, 1'b1);
    env_is("z_dcy", 24'h400000, 3'd3);
    n_gate = 1'b0;
    cyc(1'b1, 24'h400000, 1'b1);
    env_is("z_rel", 24'h400000, 3'd4);
    cyc(1'b1, 24'hC00000, 1'b1);
    env_is("z_idle", 24'h000000, 3'd0);
    drain();

    // random valid and backpressure
    do_reset();
    n_ar = 24'h001000;
    n_dr = 24'h000800;
    n_sl = 24'h600000;
    n_rr = 24'h002000;
    n_gate = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (i == 300) n_gate = 1'b0;
      cyc(1'($urandom_range(0, 1)),
          24'($urandom),
          $urandom_range(0, 3) != 0);
    end
    drain();

    // reset with samples in flight
    do_reset();
    n_ar = 24'h100000;
    n_gate = 1'b1;
    repeat (3) cyc(1'b1, 24'h7FFFFF, 1'b1);
    chk("pre_rst_valid", sout.valid, 1);
    do_reset();
    cyc(1'b1, 24'h7FFFFF, 1'b1);
    env_is("post_rst", 24'h000000, 3'd1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
